bar_peak_hold: RTL
==================

# bar_peak_hold

Downstream consumer of the microphone translator. On each `new_t` rising edge it snapshots the 16 ten-bit band values `t0`–`t15` and updates 16 bar heights, applying saturating linear decay. It also maintains 16 peak-hold markers, each with a per-channel hold timer. The display renderer reads bar and peak values one channel at a time through a registered read port.

## Interface
Parameters:
- `DECAY_STEP`, 8: amount a bar falls per frame when the new sample is lower.
- `PEAK_STEP`, 4: amount a peak marker falls per frame once its hold expires.
- `HOLD_FRAMES`, 30: frames a new peak is held before decaying; range 1..255.

Ports:
- `CLK` input 1: single system clock; all logic is on its rising edge.
- `RESETN` input 1: asynchronous, active-low reset.
- `new_t` input 1: frame-ready level from the translator, synchronous to `CLK`. Only its rising edge is meaningful.
- `t0`..`t15` input 10 each: unsigned band values. They are sampled only in the rising-edge cycle of `new_t`.
- `rd_addr` input 4: channel select for the read port.
- `rd_bar` output 10: registered bar height of channel `rd_addr`.
- `rd_peak` output 10: registered peak marker of channel `rd_addr`.
- `busy` output 1: high while a frame update is in progress.
- `frame_done` output 1: one-cycle pulse when all 16 channels have been updated.
- `overrun` output 1: one-cycle pulse when a `new_t` edge is dropped.

## Operation
Edge detect:
- `new_t_d` is registered `new_t` and resets to 1, so `new_t` already high at reset release is not an edge.
- `edge = new_t & ~new_t_d`.

FSM:
- IDLE:
  - `edge` → capture `t0..t15` into `snap[0..15]`, set `ch=0`, go to UPDATE.
- UPDATE:
  - Process channel `ch` this cycle.
  - When `ch==15`, go to DONE; otherwise `ch++`.
- DONE:
  - Assert `frame_done`, go to IDLE.
- `edge` seen in UPDATE or DONE:
  - Ignored; `snap` is not overwritten.
  - `overrun` pulses for one cycle.

Per-channel update, for `i=ch`; all arithmetic is 10-bit unsigned and saturating, never wrapping:
- `dec = (bar[i] > DECAY_STEP) ? bar[i]-DECAY_STEP : 0`.
- `bar[i] ← max(snap[i], dec)`.
- If `snap[i] >= peak[i]`: `peak[i] ← snap[i]`, `hold[i] ← HOLD_FRAMES`.
- Else if `hold[i] != 0`: `hold[i]--`, `peak[i]` unchanged.
- Else: `peak[i] ← max(sat(peak[i]-PEAK_STEP), bar_new[i])`.
- Invariant: `peak[i] >= bar[i]` at all times after any update.
- `hold[i]` width is 8 bits.

Read port:
- `rd_bar`/`rd_peak` are registered from `bar[rd_addr]`/`peak[rd_addr]`.
- Reads are allowed at any time.
- During UPDATE, channels `< ch` return new values and channels `>= ch` return old values.
- The update write and the read register sample the same edge, so a read of channel `ch` in its update cycle returns the old value.

Reset (`RESETN` low, asynchronous):
- All `bar`, `peak`, `hold`, `snap`, and `ch` are 0.
- FSM is IDLE; `new_t_d`=1.
- `rd_bar`, `rd_peak`, `busy`, `frame_done`, `overrun` are all 0.
- Reset mid-UPDATE abandons the frame with no partial result retained.

## Timing
- Edge cycle E: `new_t`=1 and `new_t_d`=0 are sampled at rising edge E, and `snap` loads at that edge.
- UPDATE occupies cycles E+1..E+16; channel k is written at the end of cycle E+1+k.
- DONE occupies cycle E+17; `frame_done` is high during that cycle only.
- `busy` is high during E+1..E+17.
- Next accepted edge: E+18 at the earliest. An edge at E+1..E+17 produces `overrun` in the following cycle.
- Read latency: 1 cycle from `rd_addr` to `rd_bar`/`rd_peak`.
- Frame throughput: `new_t` period must be ≥18 `CLK` cycles.

## Test plan
1. Reset:
   - Stimulus: hold `RESETN` low, then release; sweep `rd_addr` 0..15.
   - Required: `rd_bar`=`rd_peak`=0 for all channels; `busy`/`frame_done`/`overrun` stay 0; `new_t` held high through release gives no frame.
2. Single frame:
   - Stimulus: `t_i = 60*i`, one `new_t` rising edge.
   - Required: `frame_done` exactly 17 cycles after E; `rd_bar[i]`=`rd_peak[i]`=`60*i` (ch15=900).
3. Decay, with `DECAY_STEP`=8:
   - Stimulus: `t5`=100, then all zeros for successive frames.
   - Required: `rd_bar[5]` = 92, 84, … 4, 0 and stays 0 (13 frames, no wrap).
4. Peak hold, with `HOLD_FRAMES`=2 and `PEAK_STEP`=4:
   - Stimulus: `t3`=200, then `t3`=50 each frame.
   - Required: `peak[3]` = 200, 200, 200, 196, 192…; bar follows decay to 50; peak never falls below 50.
5. Overrun:
   - Stimulus: second `new_t` edge at E+5 carrying different `t` values.
   - Required: `overrun` pulses once; results equal the first frame only; `frame_done` at E+17.
6. Mid-update reset:
   - Stimulus: frame of all 500s; `RESETN` low at E+8.
   - Required: outputs 0 immediately; after release, a frame of all 100s gives `rd_bar`=`rd_peak`=100 for all channels.

Source files
------------

// File: rtl/bar_peak_hold_if.sv
// Frame input, read port and status bundle between the band translator,
// the display renderer and bar_peak_hold.
interface bar_peak_hold_if;
  logic       new_t;
  logic [9:0] t0, t1, t2, t3, t4, t5, t6, t7;
  logic [9:0] t8, t9, t10, t11, t12, t13, t14, t15;
  logic [3:0] rd_addr;
  logic [9:0] rd_bar;
  logic [9:0] rd_peak;
  logic       busy;
  logic       frame_done;
  logic       overrun;

  modport master (
    output new_t, t0, t1, t2, t3, t4, t5, t6, t7,
           t8, t9, t10, t11, t12, t13, t14, t15, rd_addr,
    input  rd_bar, rd_peak, busy, frame_done, overrun
  );

  modport slave (
    input  new_t, t0, t1, t2, t3, t4, t5, t6, t7,
           t8, t9, t10, t11, t12, t13, t14, t15, rd_addr,
    output rd_bar, rd_peak, busy, frame_done, overrun
  );
endinterface

// File: rtl/bar_peak_hold.sv
// 16-channel bar meter with saturating decay and timed peak-hold markers,
// updated one channel per cycle after each new_t rising edge.
module bar_peak_hold #(
  parameter int DECAY_STEP  = 8,
  parameter int PEAK_STEP   = 4,
  parameter int HOLD_FRAMES = 30
) (
  input  logic           CLK,
  input  logic           RESETN,
  bar_peak_hold_if.slave bus
);
  localparam logic [9:0] DSTEP = 10'(DECAY_STEP);
  localparam logic [9:0] PSTEP = 10'(PEAK_STEP);
  localparam logic [7:0] HOLD  = 8'(HOLD_FRAMES);

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        ch_q, ch_d;
  logic              new_t_q;
  logic              new_edge;
  logic              load, upd;
  logic              overrun_q;
  logic [9:0]        rd_bar_q, rd_peak_q;
  logic [15:0][9:0]  t_in, snap_q, bar_q, peak_q;
  logic [15:0][7:0]  hold_q;

  logic [9:0] s_snap, s_bar, s_peak, dec, pk_dec, bar_new, peak_new;
  logic [7:0] s_hold, hold_new;

  assign t_in = {bus.t15, bus.t14, bus.t13, bus.t12, bus.t11, bus.t10, bus.t9, bus.t8,
                 bus.t7,  bus.t6,  bus.t5,  bus.t4,  bus.t3,  bus.t2,  bus.t1, bus.t0};

  assign new_edge = bus.new_t & ~new_t_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    load    = 1'b0;
    upd     = 1'b0;
    case (state_q)
      IDLE: if (new_edge) begin
        load    = 1'b1;
        ch_d    = 4'd0;
        state_d = UPDATE;
      end
      UPDATE: begin
        upd = 1'b1;
        if (ch_q == 4'd15) state_d = DONE;
        else               ch_d    = ch_q + 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Update datapath for the channel selected by ch_q.
  always_comb begin
    s_snap   = snap_q[ch_q];
    s_bar    = bar_q[ch_q];
    s_peak   = peak_q[ch_q];
    s_hold   = hold_q[ch_q];
    dec      = (s_bar > DSTEP) ? s_bar - DSTEP : '0;
    bar_new  = (s_snap > dec) ? s_snap : dec;
    pk_dec   = (s_peak > PSTEP) ? s_peak - PSTEP : '0;
    peak_new = s_peak;
    hold_new = s_hold;
    if (s_snap >= s_peak) begin
      peak_new = s_snap;
      hold_new = HOLD;
    end else if (s_hold != 8'd0) begin
      hold_new = s_hold - 8'd1;
    end else begin
      // Decayed marker never drops beneath the bar it sits on.
      peak_new = (pk_dec > bar_new) ? pk_dec : bar_new;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      new_t_q   <= 1'b1;
      overrun_q <= 1'b0;
      snap_q    <= '0;
      bar_q     <= '0;
      peak_q    <= '0;
      hold_q    <= '0;
      rd_bar_q  <= '0;
      rd_peak_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      new_t_q   <= bus.new_t;
      overrun_q <= new_edge && (state_q != IDLE);
      if (load) snap_q <= t_in;
      if (upd) begin
        bar_q[ch_q]  <= bar_new;
        peak_q[ch_q] <= peak_new;
        hold_q[ch_q] <= hold_new;
      end
      // Same-edge sampling: a channel read in its own update cycle returns the old value.
      rd_bar_q  <= bar_q[bus.rd_addr];
      rd_peak_q <= peak_q[bus.rd_addr];
    end
  end

  assign bus.rd_bar     = rd_bar_q;
  assign bus.rd_peak    = rd_peak_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = (state_q == DONE);
  assign bus.overrun    = overrun_q;
endmodule
